display_scene_ctrl: RTL and testbench

//  Scene sequencer and pixel-source arbiter between the game renderer and the win/lose image displays.

---
 rtl/display_scene_ctrl.sv | 151 +++++++++++++++
 tb/tb_display_scene_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scene_ctrl.sv
// Scene sequencer and pixel-source arbiter for game / win / lose screens.
// Scene changes land only on frame ticks so a frame never tears.
module display_scene_ctrl #(
    parameter int unsigned BLINK_FRAMES  = 16,
    parameter int unsigned BLINK_TOGGLES = 6,
    parameter logic [15:0] BLANK_RGB     = 16'h0000
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        frame_tick,
    input  logic        video_on,
    input  logic        game_win,
    input  logic        game_lose,
    input  logic        restart_req,
    input  logic [15:0] game_rgb,
    input  logic [15:0] win_rgb,
    input  logic [15:0] lose_rgb,
    output logic [15:0] rgb,
    output logic [1:0]  scene,
    output logic        game_pause,
    output logic        game_restart
);

    typedef enum logic [1:0] {
        S_PLAY      = 2'b00,
        S_WIN_BLINK = 2'b01,
        S_WIN_HOLD  = 2'b10,
        S_LOSE_HOLD = 2'b11
    } state_t;

    localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [3:0] TOG_LAST   = 4'(BLINK_TOGGLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_frame_cnt;
    logic [3:0]  r_toggle_cnt;
    logic        r_blink_on;
    logic        r_win_pend;
    logic        r_lose_pend;
    logic        r_restart_pend;
    logic        w_in_play;
    logic        w_win;
    logic        w_lose;
    logic        w_restart;
    logic        w_frame_wrap;
    logic        w_blink_done;
    logic        w_to_play;
    logic        w_leave_play;
    logic        w_enter_blink;

    // Live request merges this cycle's pulse with the latch so a tick acts on it at once
    assign w_in_play     = (r_state == S_PLAY);
    assign w_win         = w_in_play & (r_win_pend | game_win);
    assign w_lose        = w_in_play & (r_lose_pend | game_lose);
    assign w_restart     = ~w_in_play & (r_restart_pend | restart_req);
    assign w_frame_wrap  = (r_frame_cnt == FRAME_LAST);
    assign w_blink_done  = w_frame_wrap & (r_toggle_cnt == TOG_LAST);
    assign w_to_play     = ~w_in_play & (w_next == S_PLAY);
    assign w_leave_play  = w_in_play & (w_next != S_PLAY);
    assign w_enter_blink = w_in_play & (w_next == S_WIN_BLINK);
    assign scene         = r_state;

    // State register
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_PLAY;
        else            r_state <= w_next;
    end

    // Next-state decode, evaluated only on frame ticks
    always_comb begin
        w_next = r_state;
        if (frame_tick) begin
            unique case (r_state)
                S_PLAY: begin
                    if (w_win)       w_next = S_WIN_BLINK;
                    else if (w_lose) w_next = S_LOSE_HOLD;
                end
                S_WIN_BLINK: begin
                    if (w_restart)         w_next = S_PLAY;
                    else if (w_blink_done) w_next = S_WIN_HOLD;
                end
                default: begin
                    if (w_restart) w_next = S_PLAY;
                end
            endcase
        end
    end

    // Request latches: captured only in the state that can honour them
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_win_pend     <= 1'b0;
            r_lose_pend    <= 1'b0;
            r_restart_pend <= 1'b0;
        end else begin
            r_win_pend     <= w_win & ~w_leave_play;
            r_lose_pend    <= w_lose & ~w_leave_play;
            r_restart_pend <= w_restart & ~w_to_play;
        end
    end

    // Blink timing: frame counter, half-period counter and phase
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_cnt  <= 8'd0;
            r_toggle_cnt <= 4'd0;
            r_blink_on   <= 1'b0;
        end else if (w_enter_blink) begin
            r_frame_cnt  <= 8'd0;
            r_toggle_cnt <= 4'd0;
            r_blink_on   <= 1'b1;
        end else if (r_state == S_WIN_BLINK && frame_tick && !w_restart) begin
            if (w_frame_wrap) begin
                r_frame_cnt  <= 8'd0;
                r_toggle_cnt <= r_toggle_cnt + 4'd1;
                r_blink_on   <= ~r_blink_on;
            end else begin
                r_frame_cnt  <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Status outputs follow the state taken at the tick
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            game_pause   <= 1'b0;
            game_restart <= 1'b0;
        end else begin
            game_pause   <= (w_next != S_PLAY);
            game_restart <= w_to_play;
        end
    end

    // Registered pixel mux
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb <= 16'h0000;
        end else if (!video_on) begin
            rgb <= 16'h0000;
        end else begin
            unique case (r_state)
                S_PLAY:      rgb <= game_rgb;
                S_WIN_BLINK: rgb <= r_blink_on ? win_rgb : BLANK_RGB;
                S_WIN_HOLD:  rgb <= win_rgb;
                default:     rgb <= lose_rgb;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scene_ctrl.sv
// Directed bench for display_scene_ctrl: pixel mux table plus
// hand-written scene sequences (blink, restart, priority, reset).
module tb_display_scene_ctrl;

    logic        vga_clk;
    logic        sys_rst_n;
    logic        frame_tick;
    logic        video_on;
    logic        game_win;
    logic        game_lose;
    logic        restart_req;
    logic [15:0] game_rgb;
    logic [15:0] win_rgb;
    logic [15:0] lose_rgb;
    logic [15:0] rgb;
    logic [1:0]  scene;
    logic        game_pause;
    logic        game_restart;

    int total = 0;
    int bad   = 0;
    int rcnt  = 0;
    int rc0;
    logic saw_lose;

    typedef struct {
        logic        vid;
        logic [15:0] g;
        logic [15:0] w;
        logic [15:0] l;
        logic [15:0] exp_rgb;
    } vec_t;

    vec_t vecs [7];

    display_scene_ctrl dut (
        .vga_clk      (vga_clk),
        .sys_rst_n    (sys_rst_n),
        .frame_tick   (frame_tick),
        .video_on     (video_on),
        .game_win     (game_win),
        .game_lose    (game_lose),
        .restart_req  (restart_req),
        .game_rgb     (game_rgb),
        .win_rgb      (win_rgb),
        .lose_rgb     (lose_rgb),
        .rgb          (rgb),
        .scene        (scene),
        .game_pause   (game_pause),
        .game_restart (game_restart)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    always @(negedge vga_clk) begin
        if (game_restart) rcnt++;
        if (scene == 2'b11) saw_lose = 1'b1;
    end

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            step();
        end
    endtask

    task automatic dark(input string nm);
        video_on = 1'b0;
        step();
        chk(nm, rgb, 16'h0000);
        video_on = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'hF800, 16'h07E0, 16'h001F, 16'hF800};
        vecs[1] = '{1'b0, 16'hF800, 16'h07E0, 16'h001F, 16'h0000};
        vecs[2] = '{1'b1, 16'h001F, 16'hFFFF, 16'h1111, 16'h001F};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 16'h2222, 16'hFFFF};
        vecs[4] = '{1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'h0000};
        vecs[5] = '{1'b1, 16'h0000, 16'hAAAA, 16'h5555, 16'h0000};
        vecs[6] = '{1'b1, 16'hA5A5, 16'h0F0F, 16'hF0F0, 16'hA5A5};

        sys_rst_n   = 1'b0;
        frame_tick  = 1'b0;
        video_on    = 1'b1;
        game_win    = 1'b0;
        game_lose   = 1'b0;
        restart_req = 1'b0;
        game_rgb    = 16'hF800;
        win_rgb     = 16'h07E0;
        lose_rgb    = 16'h001F;
        saw_lose    = 1'b0;
        repeat (3) step();
        chk("rst_rgb", rgb, 16'h0000);
        chk("rst_scene", 16'(scene), 16'd0);
        chk("rst_pause", 16'(game_pause), 16'd0);
        chk("rst_restart", 16'(game_restart), 16'd0);
        sys_rst_n = 1'b1;
        step();

        // pixel mux in PLAY
        for (int i = 0; i < 7; i++) begin
            video_on = vecs[i].vid;
            game_rgb = vecs[i].g;
            win_rgb  = vecs[i].w;
            lose_rgb = vecs[i].l;
            step();
            chk($sformatf("vec%0d", i), rgb, vecs[i].exp_rgb);
        end
        chk("play_scene", 16'(scene), 16'd0);
        chk("play_pause", 16'(game_pause), 16'd0);

        video_on = 1'b1;
        game_rgb = 16'hF800;
        win_rgb  = 16'h07E0;
        lose_rgb = 16'h001F;

        // win mid-frame, blink sequence, hold
        game_win = 1'b1;
        step();
        game_win = 1'b0;
        step();
        step();
        chk("win_wait", 16'(scene), 16'd0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("win_scene", 16'(scene), 16'd1);
        chk("win_pause", 16'(game_pause), 16'd1);
        step();
        chk("blink_first", rgb, 16'h07E0);
        step();
        tick_n(15);
        chk("blink_on1", rgb, 16'h07E0);
        tick_n(1);
        chk("blink_off", rgb, 16'h0000);
        chk("blink_off_scene", 16'(scene), 16'd1);
        tick_n(16);
        chk("blink_on2", rgb, 16'h07E0);
        dark("dark_blink");
        tick_n(63);
        chk("blink_95", 16'(scene), 16'd1);
        tick_n(1);
        chk("hold_scene", 16'(scene), 16'd2);
        chk("hold_rgb", rgb, 16'h07E0);
        dark("dark_hold");

        // win ignored in WIN_HOLD, then restart
        game_win = 1'b1;
        step();
        game_win = 1'b0;
        tick_n(2);
        chk("win_ignored", 16'(scene), 16'd2);
        rc0 = rcnt;
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        step();
        step();
        chk("rst_wait", 16'(scene), 16'd2);
        chk("rst_wait_pulse", 16'(game_restart), 16'd0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("restart_pulse", 16'(game_restart), 16'd1);
        chk("restart_scene", 16'(scene), 16'd0);
        step();
        chk("restart_low", 16'(game_restart), 16'd0);
        chk("restart_rgb", rgb, 16'hF800);
        tick_n(4);
        chk("no_reblink", 16'(scene), 16'd0);
        chk("restart_once", 16'(rcnt - rc0), 16'd1);

        // win and lose together: win wins; restart mid-blink
        saw_lose  = 1'b0;
        game_win  = 1'b1;
        game_lose = 1'b1;
        step();
        game_win  = 1'b0;
        game_lose = 1'b0;
        tick_n(1);
        chk("both_scene", 16'(scene), 16'd1);
        tick_n(40);
        chk("tog2_rgb", rgb, 16'h07E0);
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        chk("still_blink", 16'(scene), 16'd1);
        tick_n(1);
        chk("blink_restart", 16'(scene), 16'd0);
        chk("no_lose", 16'(saw_lose), 16'd0);
        tick_n(3);
        chk("lose_dropped", 16'(scene), 16'd0);

        // lose hold and restart
        game_lose = 1'b1;
        step();
        game_lose = 1'b0;
        tick_n(1);
        chk("lose_scene", 16'(scene), 16'd3);
        chk("lose_rgb", rgb, 16'h001F);
        chk("lose_pause", 16'(game_pause), 16'd1);
        dark("dark_lose");
        rc0 = rcnt;
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        tick_n(1);
        chk("lose_restart", 16'(scene), 16'd0);
        chk("lose_once", 16'(rcnt - rc0), 16'd1);
        chk("lose_play_rgb", rgb, 16'hF800);

        // event on the tick itself, then async reset mid-blink
        game_win   = 1'b1;
        frame_tick = 1'b1;
        step();
        game_win   = 1'b0;
        frame_tick = 1'b0;
        chk("same_tick", 16'(scene), 16'd1);
        tick_n(20);
        rc0 = rcnt;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_rgb", rgb, 16'h0000);
        chk("arst_scene", 16'(scene), 16'd0);
        chk("arst_pause", 16'(game_pause), 16'd0);
        step();
        step();
        sys_rst_n = 1'b1;
        tick_n(3);
        chk("post_scene", 16'(scene), 16'd0);
        chk("post_pause", 16'(game_pause), 16'd0);
        chk("post_norestart", 16'(rcnt - rc0), 16'd0);
        chk("post_rgb", rgb, 16'hF800);
        dark("dark_play");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
